// File: rtl/lsu_pkg.sv
// LSU shared types: FSM states, response error codes
// and the RV32 load/store funct3 encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } stateT;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_FAULT    = 2'b10,
        ERR_FUNCT3   = 2'b11
    } errT;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

endpackage

// File: rtl/lsu_if.sv
// LSU bundle: execute-side request, writeback-side
// response and the dmem strobes/data.
interface lsu_if;

    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [2:0]  reqFunct3;
    logic [31:0] reqWdata;

    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic [1:0]  rspErr;

    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [2:0]  memFunct3;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqAddr,
        input  reqFunct3, reqWdata, rspReady,
        input  memReadData,
        output reqReady, rspValid, rspRdata,
        output rspErr, memRead, memWrite,
        output memAddr, memFunct3, memWriteData
    );

    modport master (
        output reqValid, reqWrite, reqAddr,
        output reqFunct3, reqWdata, rspReady,
        output memReadData,
        input  reqReady, rspValid, rspRdata,
        input  rspErr, memRead, memWrite,
        input  memAddr, memFunct3, memWriteData
    );

endinterface

// File: rtl/lsu_check.sv
// Request classifier: funct3 legality, alignment and
// address range, reported as a single error code.
module lsu_check
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE_KB = 1
) (
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic        write,
    output errT         err
);

    localparam logic [31:0] LIMIT = 32'(MEM_SIZE_KB * 1024);

    logic illegal;
    logic misalign;
    logic fault;

    // funct3[1:0] is 01 for halfwords and 10 for words once legal
    always_comb begin
        illegal  = write ? !(funct3 inside {SB, SH, SW})
                         : !(funct3 inside {LB, LH, LW, LBU, LHU});
        misalign = (funct3[1:0] == 2'b01 && addr[0])
                || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        fault    = addr >= LIMIT;
        err      = ERR_OK;
        unique case (1'b1)
            illegal:                       err = ERR_FUNCT3;
            (!illegal && misalign):        err = ERR_MISALIGN;
            (!illegal && !misalign && fault): err = ERR_FAULT;
            default:                       err = ERR_OK;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, one dmem
// access cycle, response held until writeback takes it.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE_KB = 1
) (
    input logic clk,
    input logic rst_n,
    lsu_if.slave bus
);

    stateT       state;
    errT         chkErr;
    errT         errQ;
    errT         rspErrQ;
    logic        writeQ;
    logic        accept;
    logic        rspValidQ;
    logic [31:0] rspRdataQ;
    logic        memReadQ;
    logic        memWriteQ;
    logic [31:0] memAddrQ;
    logic [2:0]  memFunct3Q;
    logic [31:0] memWdataQ;

    lsu_check #(.MEM_SIZE_KB(MEM_SIZE_KB)) uCheck (
        .funct3 (bus.reqFunct3),
        .addr   (bus.reqAddr),
        .write  (bus.reqWrite),
        .err    (chkErr)
    );

    assign bus.reqReady = (state == IDLE)
                       || (state == RESP && bus.rspReady);
    assign accept = bus.reqValid && bus.reqReady;

    assign bus.rspValid     = rspValidQ;
    assign bus.rspRdata     = rspRdataQ;
    assign bus.rspErr       = rspErrQ;
    assign bus.memRead      = memReadQ;
    assign bus.memWrite     = memWriteQ;
    assign bus.memAddr      = memAddrQ;
    assign bus.memFunct3    = memFunct3Q;
    assign bus.memWriteData = memWdataQ;

    // Strobes are set on acceptance so they are high for ACCESS only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            writeQ     <= 1'b0;
            errQ       <= ERR_OK;
            rspValidQ  <= 1'b0;
            rspRdataQ  <= '0;
            rspErrQ    <= ERR_OK;
            memReadQ   <= 1'b0;
            memWriteQ  <= 1'b0;
            memAddrQ   <= '0;
            memFunct3Q <= '0;
            memWdataQ  <= '0;
        end else begin
            if (accept) begin
                writeQ    <= bus.reqWrite;
                errQ      <= chkErr;
                memReadQ  <= !bus.reqWrite && chkErr == ERR_OK;
                memWriteQ <= bus.reqWrite && chkErr == ERR_OK;
                if (chkErr == ERR_OK) begin
                    memAddrQ   <= bus.reqAddr;
                    memFunct3Q <= bus.reqFunct3;
                    memWdataQ  <= bus.reqWdata;
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept) state <= ACCESS;
                end
                ACCESS: begin
                    memReadQ  <= 1'b0;
                    memWriteQ <= 1'b0;
                    rspValidQ <= 1'b1;
                    rspErrQ   <= errQ;
                    rspRdataQ <= (errQ == ERR_OK && !writeQ)
                               ? bus.memReadData : '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rspReady) begin
                        rspValidQ <= 1'b0;
                        state     <= accept ? ACCESS : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios then random
// requests checked against a byte-array memory model.
module tb_lsu;

    logic clk;
    logic rst_n;
    lsu_if bus ();

    lsu #(.MEM_SIZE_KB(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dmem: 1 KiB of bytes, combinational read, write on clock edge
    logic [7:0]  dm [0:1023];
    logic [7:0]  refM [0:1023];
    logic [9:0]  a0, a1, a2, a3;
    logic [31:0] raw;
    int          nRd = 0;
    int          nWr = 0;
    logic [31:0] lastAddr = 0;

    always_comb begin
        a0  = bus.memAddr[9:0];
        a1  = a0 + 10'd1;
        a2  = a0 + 10'd2;
        a3  = a0 + 10'd3;
        raw = {dm[a3], dm[a2], dm[a1], dm[a0]};
        case (bus.memFunct3)
            3'd0:    bus.memReadData = {{24{raw[7]}}, raw[7:0]};
            3'd1:    bus.memReadData = {{16{raw[15]}}, raw[15:0]};
            3'd4:    bus.memReadData = {24'h0, raw[7:0]};
            3'd5:    bus.memReadData = {16'h0, raw[15:0]};
            default: bus.memReadData = raw;
        endcase
        if (!bus.memRead) bus.memReadData = 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (bus.memWrite) begin
            dm[a0] <= bus.memWriteData[7:0];
            if (bus.memFunct3 != 3'd0) dm[a1] <= bus.memWriteData[15:8];
            if (bus.memFunct3 == 3'd2) begin
                dm[a2] <= bus.memWriteData[23:16];
                dm[a3] <= bus.memWriteData[31:24];
            end
        end
        if (bus.memRead)  nRd <= nRd + 1;
        if (bus.memWrite) nWr <= nWr + 1;
        if (bus.memRead || bus.memWrite) lastAddr <= bus.memAddr;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] refErr(input logic w,
                                          input logic [2:0] f3,
                                          input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        if (w ? (f3 > 3'd2)
              : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5))
            return 2'b11;
        if (a % sz != 0) return 2'b01;
        if (a >= 32'd1024) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] loadRef(input logic [2:0] f3,
                                            input logic [31:0] a);
        longint v;
        int sz;
        sz = 1 << f3[1:0];
        v  = 0;
        for (int i = 0; i < sz; i++)
            v += longint'(refM[a + i]) << (8 * i);
        if (f3 < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
            v -= longint'(1) << (8 * sz);
        return v[31:0];
    endfunction

    // Entered and left at 1 time unit after a rising edge
    task automatic doReq(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]  e;
        logic [31:0] d;
        int r0, w0, n, sz;
        bus.reqValid  = 1'b1;
        bus.reqWrite  = w;
        bus.reqFunct3 = f3;
        bus.reqAddr   = a;
        bus.reqWdata  = wd;
        #1;
        n = 0;
        while (!bus.reqReady && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("acceptBound", 32'(n < 20), 32'd1);
        e  = refErr(w, f3, a);
        d  = 32'h0;
        sz = 1 << f3[1:0];
        if (e == 2'b00) begin
            if (w) begin
                for (int i = 0; i < sz; i++) refM[a + i] = wd[8 * i +: 8];
            end else begin
                d = loadRef(f3, a);
            end
        end
        r0 = nRd;
        w0 = nWr;
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
        chk("earlyRsp", 32'(bus.rspValid), 32'd0);
        @(posedge clk);
        #1;
        chk("rspValid", 32'(bus.rspValid), 32'd1);
        chk("rspRdata", bus.rspRdata, d);
        chk("rspErr", 32'(bus.rspErr), 32'(e));
        chk("rdPulses", 32'(nRd - r0), 32'(e == 0 && !w));
        chk("wrPulses", 32'(nWr - w0), 32'(e == 0 && w));
        if (e == 2'b00) chk("memAddr", lastAddr, a);
    endtask

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        int          rd0;
        for (int i = 0; i < 1024; i++) begin
            dm[i]   = 8'h0;
            refM[i] = 8'h0;
        end
        rst_n         = 1'b0;
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqAddr   = 32'h0;
        bus.reqFunct3 = 3'h0;
        bus.reqWdata  = 32'h0;
        bus.rspReady  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rstRspValid", 32'(bus.rspValid), 32'd0);
        chk("rstRspErr", 32'(bus.rspErr), 32'd0);
        chk("rstRdata", bus.rspRdata, 32'd0);
        chk("rstStrobes", 32'({bus.memRead, bus.memWrite}), 32'd0);
        chk("rstMemAddr", bus.memAddr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstReqReady", 32'(bus.reqReady), 32'd1);

        doReq(1'b1, 3'd2, 32'h8, 32'd10);
        doReq(1'b0, 3'd2, 32'h8, 32'd0);
        doReq(1'b0, 3'd2, 32'h6, 32'd0);
        doReq(1'b1, 3'd1, 32'h3, 32'h55);
        doReq(1'b0, 3'd2, 32'h400, 32'd0);
        doReq(1'b0, 3'd3, 32'h0, 32'd0);
        doReq(1'b1, 3'd2, 32'hC, 32'd102);
        doReq(1'b0, 3'd2, 32'hC, 32'd0);

        // stall the response while a store waits behind it
        bus.rspReady = 1'b0;
        fork
            doReq(1'b1, 3'd2, 32'h100, 32'd113);
            begin
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("stallValid", 32'(bus.rspValid), 32'd1);
                    chk("stallRdata", bus.rspRdata, 32'd102);
                    chk("stallReady", 32'(bus.reqReady), 32'd0);
                    @(posedge clk);
                end
                #1;
                bus.rspReady = 1'b1;
            end
        join
        doReq(1'b0, 3'd2, 32'h100, 32'd0);

        // reset in the middle of a store's access cycle
        rd0           = nWr;
        bus.reqValid  = 1'b1;
        bus.reqWrite  = 1'b1;
        bus.reqFunct3 = 3'd2;
        bus.reqAddr   = 32'h10;
        bus.reqWdata  = 32'd7;
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
        chk("midAccessWr", 32'(bus.memWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abortValid", 32'(bus.rspValid), 32'd0);
        chk("abortWrite", 32'(bus.memWrite), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postRstValid", 32'(bus.rspValid), 32'd0);
        chk("postRstWrite", 32'(nWr - rd0), 32'd0);
        chk("postRstReady", 32'(bus.reqReady), 32'd1);
        doReq(1'b0, 3'd2, 32'h10, 32'd0);

        for (int k = 0; k < 80; k++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) f3 = 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
            doReq(w, f3, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter MEM_SIZE_KB, default 1, size of the attached dmem in KiB; defines the legal address range 0 .. MEM_SIZE_KB*1024-1.
REQ-002 clk  in  1  clock; every register updates on the rising edge.
REQ-003 rst_n  in  1  reset; asynchronous and active-low.
REQ-004 reqValid  in  1  a memory request from the execute stage is present.
REQ-005 reqReady  out  1  the LSU accepts the request this cycle.
REQ-006 reqWrite  in  1  1 = store, 0 = load.
REQ-007 reqAddr  in  32  byte address.
REQ-008 reqFunct3  in  3  RV32 load/store funct3.
REQ-009 reqWdata  in  32  store data, right-aligned.
REQ-010 rspValid  out  1  a response is present.
REQ-011 rspReady  in  1  the writeback stage takes the response.
REQ-012 rspRdata  out  32  load result as returned by dmem; 0 for stores and errors.
REQ-013 rspErr  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
REQ-014 memRead, memWrite  out  1 each  dmem strobes.
REQ-015 memAddr  out  32; memFunct3  out  3; memWriteData  out  32  dmem address, size and data.
REQ-016 memReadData  in  32  dmem read data, combinational from memAddr/memRead.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
REQ-018 IDLE: reqReady=1; on reqValid, latch write/addr/funct3/wdata and the classified error code, then go to ACCESS.
REQ-019 Classification: funct3 not in {0,1,2,4,5} for loads or not in {0,1,2} for stores gives 11. Otherwise a halfword with addr[0]=1 or a word with addr[1:0]!=0 gives 01. Otherwise addr >= MEM_SIZE_KB*1024 gives 10. Otherwise 00. Priority is 11 > 01 > 10.
REQ-020 ACCESS, error 00: for exactly this one cycle, assert memRead (load) or memWrite (store) and drive memAddr/memFunct3/memWriteData from the latched request.
REQ-021 ACCESS, load: capture memReadData into the response register at the end of the cycle. The dmem write commits on the same edge for a store.
REQ-022 ACCESS, error != 00: keep memRead and memWrite at 0, set rspRdata to 0, and latch rspErr.
REQ-023 ACCESS always goes to RESP; the request-to-response latency is 2 cycles.
REQ-024 RESP: rspValid=1; rspRdata and rspErr stay stable until rspValid and rspReady are both high in the same cycle.
REQ-025 RESP with rspReady=1: reqReady=1. If reqValid=1 as well, accept the new request and go to ACCESS (back-to-back, one request per 2 cycles). Otherwise go to IDLE.
REQ-026 RESP with rspReady=0: reqReady=0 and the state holds indefinitely.
REQ-027 Outside ACCESS: memRead=memWrite=0, and memAddr/memFunct3/memWriteData hold their last values.
REQ-028 At most one request is outstanding; requests are never reordered or dropped.

Reset
REQ-029 While rst_n=0: state=IDLE; rspValid=0, rspRdata=0, rspErr=00, memRead=memWrite=0, memAddr=0, memFunct3=0, memWriteData=0; reqReady=1 after release.
REQ-030 Reset asserted during ACCESS or RESP aborts the operation: no response is produced and no dmem strobe appears after reset.

Structure
REQ-031 Package lsu_pkg holds the state enum, the rspErr enum and named funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-032 Sub-module lsu_check is the combinational classifier (funct3, addr, write) -> error code, parameterised by MEM_SIZE_KB.

Verification
REQ-033 Store SW addr 0x8 data 10, then LW 0x8 -> one memWrite pulse, then rspRdata=10 and rspErr=00, each response 2 cycles after acceptance.
REQ-034 LW addr 0x6 -> rspErr=01, no memRead pulse. SH addr 0x3 -> rspErr=01, no memWrite pulse.
REQ-035 LW addr 0x400 with MEM_SIZE_KB=1 -> rspErr=10, no dmem strobe. Load funct3=3 -> rspErr=11.
REQ-036 Hold rspReady=0 for 5 cycles after LW 0xC (data 102) -> rspValid and rspRdata=102 stable throughout and reqReady=0. Then release with a queued SW 0x100=113 -> the store is accepted in the same cycle and its response arrives 2 cycles later.
REQ-037 Assert rst_n low during ACCESS of SW 0x10=7 -> rspValid=0 after reset, memWrite low after reset, and the next request behaves normally.
